// File: rtl/wincrop.sv
// wincrop: crops a rectangular window out of an AXI-Stream video frame.
// Optional build macro: WINCROP_CLAMP_EN -- validates the window against the
// source frame size at each fsync and clamps width/height to the frame edge.
module wincrop #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_RESO_WIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fsync,
  input  logic [C_RESO_WIDTH-1:0]  s_width,
  input  logic [C_RESO_WIDTH-1:0]  s_height,
  input  logic [C_RESO_WIDTH-1:0]  win_left,
  input  logic [C_RESO_WIDTH-1:0]  win_top,
  input  logic [C_RESO_WIDTH-1:0]  win_width,
  input  logic [C_RESO_WIDTH-1:0]  win_height,
  input  logic                     s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                     s_axis_tuser,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     cfg_err
);

  localparam int RW = C_RESO_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [RW-1:0] x_cnt, y_cnt;
  logic [RW-1:0] lat_left, lat_top, lat_width, lat_height;
  logic          sof_pend;

  logic          win_err;
  logic [RW-1:0] eff_width, eff_height;

  logic          beat_sof, processed, in_win, last_x, last_y, accept, beat_first;
  logic [RW-1:0] px, py;
  logic [RW:0]   x_end, y_end;

`ifdef WINCROP_CLAMP_EN
  logic [RW-1:0] room_w, room_h;

  // Window validation and clamping against the source frame
  always_comb begin
    win_err    = (win_left >= s_width) || (win_top >= s_height) ||
                 (win_width == '0) || (win_height == '0);
    room_w     = s_width - win_left;
    room_h     = s_height - win_top;
    eff_width  = (win_width  < room_w) ? win_width  : room_w;
    eff_height = (win_height < room_h) ? win_height : room_h;
  end

  // Error flag captured at every fsync
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cfg_err <= 1'b0;
    else if (fsync) cfg_err <= win_err;
  end
`else
  logic unused_reso;

  // Window used as given; frame size is not needed
  always_comb begin
    win_err    = 1'b0;
    eff_width  = win_width;
    eff_height = win_height;
  end

  assign unused_reso = ^{s_width, s_height};
  assign cfg_err     = 1'b0;
`endif

  // Position of the presented beat and its window membership
  always_comb begin
    beat_sof   = s_axis_tuser && (state != IDLE);
    processed  = (state == RUN) || beat_sof;
    px         = beat_sof ? '0 : x_cnt;
    py         = beat_sof ? '0 : y_cnt;
    x_end      = {1'b0, lat_left} + {1'b0, lat_width};
    y_end      = {1'b0, lat_top}  + {1'b0, lat_height};
    in_win     = processed &&
                 (px >= lat_left) && ({1'b0, px} < x_end) &&
                 (py >= lat_top)  && ({1'b0, py} < y_end);
    last_x     = ({1'b0, px} + (RW+1)'(1)) == x_end;
    last_y     = ({1'b0, py} + (RW+1)'(1)) == y_end;
    beat_first = beat_sof || sof_pend;
    if (state == IDLE)
      s_axis_tready = 1'b0;
    else if (in_win)
      s_axis_tready = !m_axis_tvalid || m_axis_tready;
    else
      s_axis_tready = 1'b1;
    accept = s_axis_tvalid && s_axis_tready;
  end

  // Next-state logic; fsync overrides everything
  always_comb begin
    state_nx = state;
    if (fsync)
      state_nx = win_err ? IDLE : WAIT_SOF;
    else if (accept && processed)
      state_nx = (in_win && last_x && last_y) ? DONE : RUN;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Window latch, pixel counters and start-of-frame tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      lat_left   <= '0;
      lat_top    <= '0;
      lat_width  <= '0;
      lat_height <= '0;
      sof_pend   <= 1'b0;
    end else if (fsync) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      lat_left   <= win_left;
      lat_top    <= win_top;
      lat_width  <= eff_width;
      lat_height <= eff_height;
      sof_pend   <= 1'b1;
    end else if (accept && processed) begin
      // A tuser beat restarts counting from (0,0) before advancing
      if (s_axis_tlast) begin
        x_cnt <= '0;
        y_cnt <= py + RW'(1);
      end else begin
        x_cnt <= px + RW'(1);
        y_cnt <= py;
      end
      sof_pend <= in_win ? 1'b0 : beat_first;
    end
  end

  // Output register: one-cycle latency, holds until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (fsync) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (accept && in_win) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tuser  <= beat_first;
      m_axis_tlast  <= last_x;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wincrop.sv
// Scoreboard bench for wincrop: stimulus pushes expected beats, a monitor
// pops and compares each beat the DUT hands over.
module tb_wincrop;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fsync = 1'b0;
  logic [9:0] s_width = 10'd8, s_height = 10'd4;
  logic [9:0] win_left = 10'd2, win_top = 10'd1, win_width = 10'd4, win_height = 10'd2;
  logic       s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0] s_data = '0;
  logic       m_valid, m_user, m_last, m_ready;
  logic [7:0] m_data;
  logic       cfg_err;

  logic toggle = 1'b0, tog = 1'b0, ready_fix = 1'b1, stall_chk = 1'b0;
  logic mv_after;
  int   checks = 0, errors = 0;
  logic [9:0] q[$];

  assign m_ready = toggle ? tog : ready_fix;

  wincrop #(.C_PIXEL_WIDTH(8), .C_RESO_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .fsync(fsync),
    .s_width(s_width), .s_height(s_height),
    .win_left(win_left), .win_top(win_top), .win_width(win_width), .win_height(win_height),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tuser(s_user),
    .s_axis_tlast(s_last), .s_axis_tready(s_ready),
    .m_axis_tvalid(m_valid), .m_axis_tdata(m_data), .m_axis_tuser(m_user),
    .m_axis_tlast(m_last), .m_axis_tready(m_ready),
    .cfg_err(cfg_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tog = ~tog;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic ex(input logic [7:0] d, input logic u, input logic l);
    q.push_back({d, u, l});
  endtask

  // Window (2,1,4,2) on an 8x4 frame, data = {y,x}
  task automatic exp_win;
    ex(8'h12, 1, 0); ex(8'h13, 0, 0); ex(8'h14, 0, 0); ex(8'h15, 0, 1);
    ex(8'h22, 0, 0); ex(8'h23, 0, 0); ex(8'h24, 0, 0); ex(8'h25, 0, 1);
  endtask

  task automatic send_beats(input int w, input int from, input int cnt);
    logic acc;
    for (int i = from; i < from + cnt; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {4'(i / w), 4'(i % w)};
      s_user  = (i == 0);
      s_last  = ((i % w) == w - 1);
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        #4;
        acc = s_ready;
        @(posedge clk);
        if (!acc) @(negedge clk);
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: beat %0d never accepted, expected accept", i);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_user  = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 60 && q.size() != 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk(name, q.size(), 0);
  endtask

  task automatic pulse_fsync;
    @(negedge clk);
    fsync = 1'b1;
    @(posedge clk);
    #1 mv_after = m_valid;
    @(negedge clk);
    fsync = 1'b0;
  endtask

  // Monitor: compares every transferred beat and checks stall stability
  initial begin
    logic [9:0] e;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    forever begin
      @(negedge clk);
      #4;
      if (stall_chk && prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (!reset && m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0h expected no beat", {m_data, m_user, m_last});
        end else begin
          e = q.pop_front();
          chk("out_beat", {m_data, m_user, m_last}, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("idle_ready", s_ready, 0);

    // Basic crop with ready held high, then extra beats dropped in DONE
    pulse_fsync;
    chk("fsync_cfg_err", cfg_err, 0);
    chk("fsync_valid", mv_after, 0);
    exp_win;
    send_beats(8, 0, 32);
    send_beats(8, 1, 4);
    drain("basic_drain");

    // Back-pressure toggling every cycle; restart from DONE via tuser
    toggle = 1'b1;
    stall_chk = 1'b1;
    exp_win;
    send_beats(8, 0, 32);
    drain("toggle_drain");
    toggle = 1'b0;
    stall_chk = 1'b0;

    // fsync after three transferred beats with a fourth stalled
    ex(8'h12, 1, 0); ex(8'h13, 0, 0); ex(8'h14, 0, 0);
    send_beats(8, 0, 13);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ready_fix = 1'b0;
    send_beats(8, 13, 1);
    #1 chk("stalled_valid", m_valid, 1);
    chk("three_popped", q.size(), 0);
    pulse_fsync;
    chk("fsync_clears_valid", mv_after, 0);
    ready_fix = 1'b1;
    send_beats(8, 5, 3);
    exp_win;
    send_beats(8, 0, 32);
    drain("refsync_drain");

    // Resync: tuser beat arrives mid line 2
    ex(8'h12, 1, 0); ex(8'h13, 0, 0); ex(8'h14, 0, 0); ex(8'h15, 0, 1);
    ex(8'h22, 0, 0);
    send_beats(8, 0, 19);
    exp_win;
    send_beats(8, 0, 32);
    drain("resync_drain");

    // Reset mid-frame with an output beat pending
    ready_fix = 1'b0;
    send_beats(8, 0, 11);
    #1 chk("pre_reset_valid", m_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_flags", {m_user, m_last, cfg_err}, 0);
    chk("mid_rst_ready", s_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    ready_fix = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("post_rst_idle_ready", s_ready, 0);
    chk("post_rst_valid", m_valid, 0);

    // Window partly beyond the right edge of the frame
    win_left = 10'd6; win_top = 10'd0; win_width = 10'd4; win_height = 10'd2;
    pulse_fsync;
    chk("edge_cfg_err", cfg_err, 0);
`ifdef WINCROP_CLAMP_EN
    ex(8'h06, 1, 0); ex(8'h07, 0, 1); ex(8'h16, 0, 0); ex(8'h17, 0, 1);
`else
    ex(8'h06, 1, 0); ex(8'h07, 0, 0); ex(8'h16, 0, 0); ex(8'h17, 0, 0);
`endif
    send_beats(8, 0, 32);
    drain("edge_drain");

    // Window entirely outside the frame
    win_left = 10'd8;
    pulse_fsync;
`ifdef WINCROP_CLAMP_EN
    chk("out_cfg_err", cfg_err, 1);
    #1 chk("out_ready", s_ready, 0);
`else
    chk("out_cfg_err", cfg_err, 0);
    #1 chk("out_ready", s_ready, 1);
    send_beats(8, 0, 32);
    drain("out_drain");
    #1 chk("out_never_done_ready", s_ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wincrop.md
WINCROP -- requirements
Module: wincrop

Interface
REQ-001 SHALL have parameter C_PIXEL_WIDTH, default 8, pixel bits per beat.
REQ-002 SHALL have parameter C_RESO_WIDTH, default 10, bits of every resolution/coordinate port.
REQ-003 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have fsync  input  1  synchronous frame restart pulse.
REQ-006 SHALL have s_width, s_height  input  C_RESO_WIDTH each  source frame size.
REQ-007 SHALL have win_left, win_top, win_width, win_height  input  C_RESO_WIDTH each  crop window.
REQ-008 SHALL have s_axis_tvalid/tdata/tuser/tlast  input  1/C_PIXEL_WIDTH/1/1, and s_axis_tready  output  1  (source video stream).
REQ-009 SHALL have m_axis_tvalid/tdata/tuser/tlast  output  1/C_PIXEL_WIDTH/1/1, and m_axis_tready  input  1  (cropped stream feeding the scaler).
REQ-010 SHALL have cfg_err  output  1  window rejected at last latch.

Function
REQ-011 SHALL implement states IDLE, WAIT_SOF, RUN, DONE.
REQ-012 SHALL, on fsync=1 in any state, latch all window inputs, clear m_axis_tvalid, zero x/y counters, enter WAIT_SOF; fsync has priority over every other event.
REQ-013 SHALL hold s_axis_tready=0 in IDLE.
REQ-014 SHALL, in WAIT_SOF, accept and drop beats until an accepted beat has tuser=1; that beat is pixel (x=0,y=0), processed as RUN, state becomes RUN.
REQ-015 SHALL, in RUN, increment x per accepted beat; accepted beat with tlast=1 sets x=0, y=y+1.
REQ-016 SHALL, in RUN, treat an accepted tuser=1 beat as (0,0) (resync), discarding partial-frame counters.
REQ-017 SHALL pass a beat iff left<=x<left+width and top<=y<top+height, sums computed in C_RESO_WIDTH+1 bits (no wrap).
REQ-018 SHALL drive s_axis_tready combinationally: 1 for beats to be dropped (WAIT_SOF/RUN/DONE), ~m_axis_tvalid||m_axis_tready for beats to be passed.
REQ-019 SHALL register passed beats into m_axis_* with exactly 1-cycle latency; m_axis_tvalid holds with stable data until m_axis_tready=1.
REQ-020 SHALL set m_axis_tuser=1 only on the first passed beat of a frame, m_axis_tlast=1 only on beats with x=left+width-1.
REQ-021 SHALL enter DONE after passing (left+width-1, top+height-1); DONE drops all beats; a tuser=1 beat in DONE restarts RUN at (0,0) with the latched window.
REQ-022 SHALL keep m_axis_tdata unchanged when no beat is loaded.

Reset
REQ-023 SHALL, while reset=1, asynchronously force state=IDLE, x=y=0, latched window=0, m_axis_tvalid/tuser/tlast=0, m_axis_tdata=0, cfg_err=0.
REQ-024 SHALL stay in IDLE after reset release until the first fsync; reset mid-frame discards the in-flight output beat.

Configuration
REQ-025 SHALL, with macro WINCROP_CLAMP_EN defined, check at each fsync latch: win_left>=s_width, win_top>=s_height, win_width=0 or win_height=0 -> cfg_err=1, state IDLE; else cfg_err=0, effective width=min(win_width, s_width-win_left), height=min(win_height, s_height-win_top).
REQ-026 SHALL, without WINCROP_CLAMP_EN, use latched values unmodified, tie cfg_err=0; out-of-frame windows pass no beats and never reach DONE.

Verification
REQ-027 SHALL cover: 8x4 frame, window (2,1,4,2), m_axis_tready=1 -> 8 beats out, pixels x2..5 of lines 1..2, tuser on first, tlast on beats 4 and 8.
REQ-028 SHALL cover: same window, m_axis_tready toggled 1/0 each cycle -> identical 8-beat output, no beat lost/duplicated, tdata stable while stalled.
REQ-029 SHALL cover: fsync asserted after 3 output beats -> m_axis_tvalid=0 next cycle, WAIT_SOF, next frame output restarts with tuser=1.
REQ-030 SHALL cover: tuser=1 beat arriving mid-line 2 -> counters resync to (0,0), following output frame correct.
REQ-031 SHALL cover: WINCROP_CLAMP_EN, s_width=8, window (6,0,4,2) -> cfg_err=0, 2 beats per line; window (8,0,4,2) -> cfg_err=1, s_axis_tready=0.
REQ-032 SHALL cover: reset asserted mid-frame with m_axis_tvalid=1 -> all outputs 0 immediately, IDLE until fsync.
